bcd_countdown_timer: RTL
========================

Name: bcd_countdown_timer

Overview:
Parametrised multi-digit BCD countdown timer.
- Chains DIGITS decimal digits with a borrow ripple and adds a tick prescaler.
- Control FSM: idle/run/pause/done, with optional auto-reload.
- Feeds seven-segment display drivers and raises a terminal-count pulse for board-level sequencing such as alarms and traffic-light phases.

Parameters:
DIGITS, 4, number of BCD digits (count width = 4*DIGITS)
TICK_DIV, 1, clock cycles per count tick while RUNNING (>=1; 1 = every cycle)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
clear  input  1  abort to IDLE, count forced to 0
load  input  1  capture load_value into count and reload register
load_value  input  4*DIGITS  BCD preset; digit i at [4i+3:4i]
start  input  1  begin or resume counting
pause  input  1  freeze counting
auto_reload  input  1  1 = periodic mode, 0 = one-shot
count  output  4*DIGITS  current BCD value
state  output  2  0=IDLE 1=RUNNING 2=PAUSED 3=DONE
done  output  1  one-cycle pulse on terminal count
expired  output  1  level; high while in DONE

Behaviour:
- Clock and reset: all state updates on posedge clk. Reset, clk and clear are synchronous.
- Control priority: reset > clear > load > start/pause > tick.
- Reset values: count=0, reload reg=0, prescaler=0, state=IDLE, done=0, expired=0.
- clear (any state): count=0, prescaler=0, state=IDLE, expired=0, done=0. Reload reg is kept.
- load:
  - Accepted in IDLE, PAUSED and DONE; ignored in RUNNING.
  - Writes count and reload reg.
  - Any digit >9 is clamped to 9 (e.g. 4'hC -> 9).
  - DONE -> IDLE with expired=0; PAUSED remains PAUSED.
- FSM:
  - IDLE: start and count!=0 -> RUNNING, prescaler=0. start and count==0 -> DONE, with done=1 for one cycle and expired=1.
  - RUNNING: pause -> PAUSED (start is ignored if both are high).
  - PAUSED: start and !pause -> RUNNING; prescaler value is held, not reset.
  - DONE: start is ignored; leave only via load, clear or reset.
- Prescaler:
  - Increments every RUNNING cycle.
  - tick = (prescaler==TICK_DIV-1), after which the prescaler wraps to 0.
  - Frozen in any other state.
- Decrement on tick:
  - Digit 0 always decrements. Digit i decrements only if digits 0..i-1 are all 0 (borrow).
  - A digit at 0 receiving a borrow wraps to 9.
  - Example: 1000 -> 0999.
  - Count is registered, so the new value is visible the cycle after the tick edge.
- Terminal tick (tick with count==1):
  - count becomes 0 and done=1 on the same edge.
  - auto_reload=0: state -> DONE, expired=1.
  - auto_reload=1: remain RUNNING; the next tick loads count from the reload reg instead of decrementing.
  - Period in auto-reload mode = (reload+1)*TICK_DIV cycles.
- Zero underflow: in RUNNING with count==0, a tick with auto_reload=0 goes to DONE without wrapping to all-9s. This can only happen if count was cleared externally.
- auto_reload and reload reg = 0: count stays 0 and done pulses on every tick.
- auto_reload changes: sampled only on the terminal tick and the zero tick; changes mid-count have no other effect.
- done: exactly one cycle wide per terminal event; never asserted in IDLE except from start-at-zero.
- Reset or clear mid-count: takes effect on that edge; no done pulse.

Decomposition:
- Package bcd_timer_pkg:
  - state encoding constants (IDLE/RUNNING/PAUSED/DONE)
  - BCD_MAX = 4'd9
  - digit-clamp function (v>9 ? 9 : v)
  - prescaler width = $clog2(TICK_DIV) with min 1
- Sub-module bcd_digit_down: one digit.
  - Inputs: clk, reset, clr, ld, ld_val, dec, borrow_in, reload_val.
  - Outputs: digit, is_zero.
  - Instantiated DIGITS times via generate.
  - Top level holds the FSM, prescaler and borrow/all-zero chain.

Test Plan:
1. DIGITS=4, TICK_DIV=1: load 0012, start, auto_reload=0 -> count 0011, 0010, 0009 … 0000. done pulses exactly once as count hits 0000 on the 12th tick; state=3, expired=1.
2. Borrow ripple: load 1000, start -> next value 0999. Load 0100 -> 0099.
3. TICK_DIV=3, load 0003, auto_reload=1 -> decrements every 3 cycles. done every 12 cycles (sequence 3,2,1,0,3…); state stays RUNNING.
4. Pause/resume: pause at count 0005 with prescaler=1 -> count and prescaler frozen for 10 cycles. start -> next tick after 1 more cycle (TICK_DIV=3).
5. Clamp and precedence:
   - load 4'hF digits (FFFF) -> count 9999.
   - load and start together in IDLE -> load wins, state stays IDLE.
   - clear together with load -> count 0000, IDLE.
6. Start at zero and mid-op reset:
   - In IDLE with count 0000, start -> DONE, done=1 for one cycle.
   - Reset while RUNNING at 0042 -> count 0000, IDLE, no done pulse.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared state encoding, BCD limits and sizing helpers for the countdown timer
package bcd_timer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    return v > BCD_MAX ? BCD_MAX : v;
  endfunction
  function automatic int psc_width(input int div);
    return div > 1 ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one BCD down-counting digit with load, reload and borrow-gated decrement
module bcd_digit_down
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       dec,
  input  logic       borrow_in,
  input  logic       rl,
  input  logic [3:0] reload_val,
  output logic [3:0] digit,
  output logic       is_zero
);
  assign is_zero = digit == 4'd0;
  always_ff @(posedge clk) begin
    if (reset || clr) digit <= 4'd0;
    else if (ld) digit <= ld_val;
    else if (rl) digit <= reload_val;
    else if (dec && borrow_in) digit <= is_zero ? BCD_MAX : digit - 4'd1;
  end
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: multi-digit BCD countdown with prescaler, idle/run/pause/done control and auto-reload
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  auto_reload,
  output logic [4*DIGITS-1:0]   count,
  output logic [1:0]            state,
  output logic                  done,
  output logic                  expired
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = psc_width(TICK_DIV);
  state_t st, st_nx;
  logic [PW-1:0] psc, psc_nx;
  logic [W-1:0] reload_q, ld_val;
  logic [DIGITS:0] borrow;
  logic [DIGITS-1:0] zero;
  logic ld_ok, tick, all_zero, is_one, done_nx;
  assign ld_ok    = load && st != RUNNING;
  assign tick     = st == RUNNING && !pause && psc == PW'(TICK_DIV - 1);
  assign all_zero = borrow[DIGITS];
  assign is_one   = count == W'(1);
  assign borrow[0] = 1'b1;
  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_digit
      assign ld_val[4*i+:4] = clamp_digit(load_value[4*i+:4]);
      assign borrow[i+1]    = borrow[i] & zero[i];
      // A zero count never wraps: it either reloads (periodic) or stops
      bcd_digit_down u_digit (
        .clk(clk),
        .reset(reset),
        .clr(clear),
        .ld(ld_ok),
        .ld_val(ld_val[4*i+:4]),
        .dec(tick && !all_zero),
        .borrow_in(borrow[i]),
        .rl(tick && all_zero && auto_reload),
        .reload_val(reload_q[4*i+:4]),
        .digit(count[4*i+:4]),
        .is_zero(zero[i])
      );
    end
  endgenerate
  always_comb begin
    st_nx   = st;
    psc_nx  = psc;
    done_nx = 1'b0;
    if (ld_ok) st_nx = st == PAUSED ? PAUSED : IDLE;
    else if (st == IDLE && start) begin
      st_nx   = all_zero ? DONE : RUNNING;
      psc_nx  = '0;
      done_nx = all_zero;
    end
    else if (st == PAUSED && start && !pause) st_nx = RUNNING;
    else if (st == RUNNING && pause) st_nx = PAUSED;
    else if (st == RUNNING) begin
      psc_nx = tick ? '0 : psc + PW'(1);
      if (tick && (is_one || all_zero)) begin
        done_nx = is_one || (auto_reload && reload_q == '0);
        st_nx   = auto_reload ? RUNNING : DONE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      psc      <= '0;
      done     <= 1'b0;
      reload_q <= '0;
    end else if (clear) begin
      st   <= IDLE;
      psc  <= '0;
      done <= 1'b0;
    end else begin
      st   <= st_nx;
      psc  <= psc_nx;
      done <= done_nx;
      if (ld_ok) reload_q <= ld_val;
    end
  end
  assign state   = st;
  assign expired = st == DONE;
endmodule
